storage_core: RTL and testbench
===============================

# storage_core

Storage datapath directly downstream of the opcode controller. It consumes the 4-bit opcode together with a one-cycle `op_valid` strobe and executes buffer (random-access), FIFO or LIFO operations on a single shared memory array. It returns registered read data, a read-valid pulse, occupancy flags and an overflow/underflow error pulse to the surrounding design.

## Interface
Parameters:
- `DATA_W`, default 8: data word width.
- `DEPTH`, default 8: number of entries; power of 2, at least 2.
- `ADDR_W`, default $clog2(DEPTH): address width; derived, never overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  executes `opcode` on this edge when 1.
- `opcode`  in  4  [3:2] family (01 buffer, 10 FIFO, 11 LIFO); [1:0] op (01 write, 10 read, 00/11 NOP).
- `data_in`  in  DATA_W  write data.
- `addr`  in  ADDR_W  buffer-mode address; ignored in FIFO and LIFO modes.
- `data_out`  out  DATA_W  registered read data; holds its value between reads.
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated by a read.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  ADDR_W+1  FIFO/LIFO occupancy.
- `err`  out  1  one-cycle pulse on overflow, underflow or illegal family.

## Operation
- Reset (`reset`=0, asynchronous): `wr_ptr`, `rd_ptr`, `count`, `data_out`, `data_valid` and `err` go to 0; `empty`=1, `full`=0; mode state goes to M_NONE. Memory contents are not cleared.
- Mode FSM states: M_NONE, M_FIFO, M_LIFO. An executed FIFO write or read, when the state is not M_FIFO, first flushes (pointers and count set to 0) and enters M_FIFO; LIFO behaves the same way into M_LIFO. The op then runs against the flushed state: a read after a flush underflows. NOPs, including 10_00 and 11_00 (blocked), never change mode.
- Buffer write: mem[addr] <= data_in. Buffer read: data_out <= mem[addr], data_valid pulses. Buffer ops leave pointers, count and mode unchanged.
- FIFO write: if not full, mem[wr_ptr] <= data_in, wr_ptr+1 (wraps modulo DEPTH), count+1. If full: no write, err pulses.
- FIFO read: if not empty, data_out <= mem[rd_ptr], rd_ptr+1 (wraps), count-1, data_valid pulses. If empty: data_out holds, err pulses.
- LIFO write (push): if not full, mem[count] <= data_in, count+1. If full: err pulses.
- LIFO read (pop): if not empty, data_out <= mem[count-1], count-1, data_valid pulses. If empty: err pulses.
- Family 00, or any X/Z on `opcode`, while `op_valid`=1: treated as a NOP and err pulses. Op 00 or 11 in a legal family: NOP with no err.
- `op_valid`=0: nothing changes; data_valid=0, err=0.
- At most one operation per cycle, so no simultaneous read/write case arises.

## Timing
- Every accepted op commits on the rising edge where `op_valid`=1.
- Read latency is 1: `data_out` and `data_valid` are valid in the cycle after the strobe edge.
- `count`, `full` and `empty` reflect the op from the same edge. `full` and `empty` decode combinationally from the registered `count`.
- `err` and `data_valid` are registered pulses and never high together.
- Reset asserted mid-sequence clears the outputs immediately, without waiting for a clock edge. The first op after reset release behaves exactly as it would from power-up.

## Structure
- Package `storage_pkg` holds:
  - Opcode constants: OP_BUF_WR=0101, OP_BUF_RD=0110, OP_FIFO_WR=1001, OP_FIFO_RD=1010, OP_LIFO_WR=1101, OP_LIFO_RD=1110.
  - Family constants.
  - The mode enum `storage_mode_t` {M_NONE, M_FIFO, M_LIFO}.
- Sub-module `storage_ram`: DEPTH×DATA_W array with one synchronous write port and one registered read port, no reset on the array. Pointer, count and FSM logic stay in `storage_core`.

## Test plan
- Reset, then FIFO write of 0x11, 0x22, 0x33, then 3 FIFO reads -> data_out = 0x11, 0x22, 0x33, each one cycle after its strobe; count goes 3,2,1,0; empty=1 at the end.
- LIFO push 0xA1, 0xA2, 0xA3, then 3 pops -> 0xA3, 0xA2, 0xA1; err never asserted.
- FIFO fill with 8 writes -> full=1, count=8. 9th write -> err pulse, count stays 8. Then 8 reads and 8 writes, repeated twice -> pointer wrap correct, data returned in order.
- Read on empty FIFO -> err=1 for one cycle, data_valid=0, data_out unchanged. Push 0x55 in LIFO mode, then a FIFO read -> flush, underflow err, count=0.
- Buffer write 0x7E to addr 5, then buffer read at addr 5 -> data_out=0x7E. count and mode unchanged while a FIFO holding 2 entries stays intact.
- Assert reset for one cycle mid-way through FIFO traffic (count=4) -> count=0, data_out=0 immediately. Subsequent write then read returns the new data.

Source files
------------

// File: rtl/storage_pkg.sv
// Shared opcode, family and mode definitions for the storage datapath.
package storage_pkg;

  localparam logic [1:0] FAM_NONE = 2'b00;
  localparam logic [1:0] FAM_BUF  = 2'b01;
  localparam logic [1:0] FAM_FIFO = 2'b10;
  localparam logic [1:0] FAM_LIFO = 2'b11;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  localparam logic [3:0] OP_BUF_WR  = 4'b0101;
  localparam logic [3:0] OP_BUF_RD  = 4'b0110;
  localparam logic [3:0] OP_FIFO_WR = 4'b1001;
  localparam logic [3:0] OP_FIFO_RD = 4'b1010;
  localparam logic [3:0] OP_LIFO_WR = 4'b1101;
  localparam logic [3:0] OP_LIFO_RD = 4'b1110;

  typedef enum logic [1:0] {
    M_NONE = 2'd0,
    M_FIFO = 2'd1,
    M_LIFO = 2'd2
  } storage_mode_t;

endpackage

// File: rtl/storage_ram.sv
// Storage array: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register is.
module storage_ram
  import storage_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read register holds its value between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/storage_core.sv
// Storage datapath: buffer / FIFO / LIFO operations on one shared array.
//
// state  | meaning
// M_NONE | no queue mode entered since reset
// M_FIFO | pointers and count track a FIFO
// M_LIFO | count tracks a stack top (rd/wr pointers idle)
//
// Entering FIFO or LIFO from any other mode flushes pointers and count,
// and the op that caused the switch runs against the flushed state.
module storage_core
  import storage_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  storage_mode_t     mode_q, mode_d, target;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              dv_q, dv_d, err_q, err_d;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [1:0]        fam, op;
  logic              illegal, flush;
  logic [ADDR_W-1:0] base_wr, base_rd;
  logic [ADDR_W:0]   base_cnt;
  logic              base_full, base_empty;

  assign fam     = opcode[3:2];
  assign op      = opcode[1:0];
  assign illegal = $isunknown(opcode) || (fam == FAM_NONE);
  assign target  = (fam == FAM_LIFO) ? M_LIFO : M_FIFO;
  assign flush   = (mode_q != target);

  assign base_wr    = flush ? '0 : wr_ptr_q;
  assign base_rd    = flush ? '0 : rd_ptr_q;
  assign base_cnt   = flush ? '0 : count_q;
  assign base_full  = (base_cnt == CNT_FULL);
  assign base_empty = (base_cnt == '0);

  // mode/pointer/count registers and output pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= M_NONE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end

  // opcode decode: next mode, pointers, count, array access and pulses
  always_comb begin
    mode_d    = mode_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = addr;
    mem_raddr = addr;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    if (op_valid) begin
      if (illegal) begin
        err_d = 1'b1;
      end else if (fam == FAM_BUF) begin
        if (op == OP_WR) begin
          mem_we = 1'b1;
        end else if (op == OP_RD) begin
          mem_re = 1'b1;
          dv_d   = 1'b1;
        end
      end else if ((op == OP_WR) || (op == OP_RD)) begin
        mode_d   = target;
        wr_ptr_d = base_wr;
        rd_ptr_d = base_rd;
        count_d  = base_cnt;
        if (op == OP_WR) begin
          if (base_full) begin
            err_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = base_cnt + CNT_ONE;
            if (fam == FAM_FIFO) begin
              mem_waddr = base_wr;
              wr_ptr_d  = base_wr + PTR_ONE;
            end else begin
              mem_waddr = base_cnt[ADDR_W-1:0];
            end
          end
        end else begin
          if (base_empty) begin
            err_d = 1'b1;
          end else begin
            mem_re  = 1'b1;
            dv_d    = 1'b1;
            count_d = base_cnt - CNT_ONE;
            if (fam == FAM_FIFO) begin
              mem_raddr = base_rd;
              rd_ptr_d  = base_rd + PTR_ONE;
            end else begin
              mem_raddr = count_d[ADDR_W-1:0];
            end
          end
        end
      end
    end
  end

  storage_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (data_in),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (data_out)
  );

  assign count      = count_q;
  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign data_valid = dv_q;
  assign err        = err_q;

endmodule

// File: tb/tb_storage_core.sv
// Directed bench for storage_core with a read-data scoreboard.
module tb_storage_core;
  import storage_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic          op_valid;
  logic [3:0]    opcode;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] fm [$];
  logic [DW-1:0] last_rd = '0;

  storage_core #(.DATA_W(DW), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .opcode     (opcode),
    .data_in    (data_in),
    .addr       (addr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no summary, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one strobed op; reads push their expected data, pops happen on data_valid
  task automatic step(input logic [3:0] opc, input logic [DW-1:0] d, input logic [AW-1:0] a,
                      input bit exp_rd, input logic [DW-1:0] exp_d, input bit exp_err);
    logic [DW-1:0] t;
    op_valid = 1'b1;
    opcode   = opc;
    data_in  = d;
    addr     = a;
    if (exp_rd) sb.push_back(exp_d);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    chk("data_valid", 32'(data_valid), 32'(exp_rd));
    chk("err", 32'(err), 32'(exp_err));
    if (data_valid) begin
      if (sb.size() > 0) begin
        t = sb.pop_front();
        chk("rdata", 32'(data_out), 32'(t));
        last_rd = t;
      end
    end else if (exp_rd && sb.size() > 0) begin
      void'(sb.pop_back());
    end
  endtask

  task automatic fwr(input logic [DW-1:0] d);
    fm.push_back(d);
    step(OP_FIFO_WR, d, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic frd();
    logic [DW-1:0] e;
    e = fm.pop_front();
    step(OP_FIFO_RD, '0, '0, 1'b1, e, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    op_valid = 1'b0;
    opcode   = '0;
    data_in  = '0;
    addr     = '0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // FIFO order
    fwr(8'h11); chk("cnt_w1", 32'(count), 32'd1);
    fwr(8'h22); chk("cnt_w2", 32'(count), 32'd2);
    fwr(8'h33); chk("cnt_w3", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      frd();
      chk("cnt_rd", 32'(count), 32'(2 - i));
    end
    chk("fifo_empty", 32'(empty), 32'd1);

    // LIFO order
    step(OP_LIFO_WR, 8'hA1, '0, 1'b0, '0, 1'b0);
    step(OP_LIFO_WR, 8'hA2, '0, 1'b0, '0, 1'b0);
    step(OP_LIFO_WR, 8'hA3, '0, 1'b0, '0, 1'b0);
    chk("lifo_cnt", 32'(count), 32'd3);
    step(OP_LIFO_RD, '0, '0, 1'b1, 8'hA3, 1'b0);
    step(OP_LIFO_RD, '0, '0, 1'b1, 8'hA2, 1'b0);
    step(OP_LIFO_RD, '0, '0, 1'b1, 8'hA1, 1'b0);
    chk("lifo_cnt0", 32'(count), 32'd0);

    // FIFO fill, overflow, then wrap twice
    for (int i = 0; i < 8; i++) fwr(8'(8'h40 + i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_cnt", 32'(count), 32'd8);
    step(OP_FIFO_WR, 8'hEE, '0, 1'b0, '0, 1'b1);
    chk("ovf_cnt", 32'(count), 32'd8);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) frd();
      chk("wrap_empty", 32'(empty), 32'd1);
      for (int i = 0; i < 8; i++) fwr(8'(8'h80 + 16 * r + i));
      chk("wrap_full", 32'(full), 32'd1);
    end
    for (int i = 0; i < 8; i++) frd();

    // underflow on empty FIFO holds data_out
    step(OP_FIFO_RD, '0, '0, 1'b0, '0, 1'b1);
    chk("unf_dout", 32'(data_out), 32'(last_rd));
    chk("unf_cnt", 32'(count), 32'd0);

    // LIFO push then FIFO read: flush then underflow
    step(OP_LIFO_WR, 8'h55, '0, 1'b0, '0, 1'b0);
    chk("push55_cnt", 32'(count), 32'd1);
    step(OP_FIFO_RD, '0, '0, 1'b0, '0, 1'b1);
    chk("flush_cnt", 32'(count), 32'd0);

    // buffer ops beside a live FIFO, plus NOPs and illegal family
    fwr(8'hC1);
    fwr(8'hC2);
    step(OP_BUF_WR, 8'h7E, 3'd5, 1'b0, '0, 1'b0);
    step(OP_BUF_RD, '0, 3'd5, 1'b1, 8'h7E, 1'b0);
    chk("buf_cnt", 32'(count), 32'd2);
    step(4'b1100, '0, '0, 1'b0, '0, 1'b0);
    step(4'b1000, '0, '0, 1'b0, '0, 1'b0);
    chk("nop_cnt", 32'(count), 32'd2);
    step(4'b0001, 8'h99, '0, 1'b0, '0, 1'b1);
    step(4'b0010, '0, '0, 1'b0, '0, 1'b1);
    frd();
    frd();
    chk("buf_fifo_cnt", 32'(count), 32'd0);

    // asynchronous reset in the middle of FIFO traffic
    for (int i = 0; i < 4; i++) fwr(8'(8'hD0 + i));
    chk("pre_rst_cnt", 32'(count), 32'd4);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_dout", 32'(data_out), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    fm.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    fwr(8'h99);
    chk("post_rst_cnt", 32'(count), 32'd1);
    frd();
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
